// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Holds the program counter and an internal synchronous instruction RAM,
// and presents the fetched word on i_bus. i_valid tells the control unit
// whether i_bus matches RAM[pc] for the current pc and RAM contents.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_STALE | i_bus is not RAM[pc]: pc moved, RAM[pc] written, or reset
// ST_VALID | i_bus holds RAM[pc] for the current pc and RAM contents

module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_increment,
    input  logic                  pc_load,
    input  logic [15:0]           d_bus,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [15:0]           prog_data,
    output logic [15:0]           i_bus,
    output logic                  i_valid,
    output logic [ADDR_WIDTH-1:0] pc
);

    localparam int          DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [15:0] NOP_WORD = 16'hFFFF;

    typedef enum logic {
        ST_STALE = 1'b0,
        ST_VALID = 1'b1
    } fetch_state_t;

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;
    logic [15:0]           i_bus_q;
    logic [15:0]           mem [DEPTH];
    logic                  pc_changes;
    logic                  write_hits_pc;
    logic                  stale_event;

    // Only the low ADDR_WIDTH bits of d_bus are meaningful as a jump target.
    logic unused_d_bus;
    assign unused_d_bus = ^d_bus;

    // Any load counts as a pc change, even if the target equals the current pc.
    assign pc_changes    = pc_load | pc_increment;
    assign write_hits_pc = prog_we && (prog_addr == pc_q);
    assign stale_event   = pc_changes | write_hits_pc;

    // Next pc: load beats increment; increment wraps modulo the RAM depth.
    always_comb begin
        pc_d = pc_q;
        if (pc_load) begin
            pc_d = d_bus[ADDR_WIDTH-1:0];
        end else if (pc_increment) begin
            pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    // Program counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Instruction RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Registered fetch of the pre-update pc; reads old data on a same-edge write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_bus_q <= NOP_WORD;
        end else begin
            i_bus_q <= mem[pc_q];
        end
    end

    // Validity state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STALE;
        end else begin
            state_q <= state_d;
        end
    end

    // Validity next state: any stale event forces STALE, otherwise VALID.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_VALID: state_d = stale_event ? ST_STALE : ST_VALID;
            ST_STALE: state_d = stale_event ? ST_STALE : ST_VALID;
            default:  state_d = ST_STALE;
        endcase
    end

    // Validity output decode.
    always_comb begin
        i_valid = 1'b0;
        if (state_q == ST_VALID) begin
            i_valid = 1'b1;
        end
    end

    assign i_bus = i_bus_q;
    assign pc    = pc_q;

endmodule
